// File: rtl/alu_result_buffer8_pkg.sv
// Shared types for the ALU result buffer: FSM encoding, data width and flag bundle.
// Parity storage is included only when ALU_PARITY_FLAG_EN is defined.
package alu_result_buffer8_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic z;
        logic n;
`ifdef ALU_PARITY_FLAG_EN
        logic p;
`endif
    } flags_t;

endpackage

// File: rtl/alu_result_buffer8_flag8.sv
// Combinational status-flag generator for one 8-bit result.
// Produces the parity flag only when ALU_PARITY_FLAG_EN is defined.
module alu_result_buffer8_flag8
    import alu_result_buffer8_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output flags_t            flags_o
);

    always_comb begin
        flags_o   = '0;
        flags_o.z = (data_i == '0);
        flags_o.n = data_i[DATA_W-1];
`ifdef ALU_PARITY_FLAG_EN
        flags_o.p = ^data_i;
`endif
    end

endmodule

// File: rtl/alu_result_buffer8.sv
// Two-entry skid-buffered output stage for 8-bit logic-unit results with Z/N flags.
// Defining ALU_PARITY_FLAG_EN adds the OUT_P parity flag port and its storage.
module alu_result_buffer8
    import alu_result_buffer8_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_Z,
    output logic              OUT_N,
`ifdef ALU_PARITY_FLAG_EN
    output logic              OUT_P,
`endif
    output logic [7:0]        DCNT
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, skid_data_q;
    flags_t            main_flags_q, skid_flags_q;
    flags_t            in_flags;
    logic [7:0]        dcnt_q;

    logic push, pop;
    logic load_main_in, load_main_skid, load_skid;

    alu_result_buffer8_flag8 u_flag8 (
        .data_i  (IN_DATA),
        .flags_o (in_flags)
    );

    // Ready comes only from registered state and reset, never from OUT_READY.
    assign IN_READY  = (state_q != ST_TWO) && !RST;
    assign OUT_VALID = (state_q != ST_EMPTY);
    assign push      = IN_VALID && IN_READY;
    assign pop       = OUT_VALID && OUT_READY;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d      = ST_ONE;
                    load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (push && !pop) begin
                    state_d   = ST_TWO;
                    load_skid = 1'b1;
                end else if (pop && !push) begin
                    state_d = ST_EMPTY;
                end else if (push && pop) begin
                    load_main_in = 1'b1;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_d        = ST_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_EMPTY;
            main_data_q  <= '0;
            main_flags_q <= '0;
            skid_data_q  <= '0;
            skid_flags_q <= '0;
            dcnt_q       <= 8'h00;
        end else begin
            state_q <= state_d;
            if (load_main_in) begin
                main_data_q  <= IN_DATA;
                main_flags_q <= in_flags;
            end else if (load_main_skid) begin
                main_data_q  <= skid_data_q;
                main_flags_q <= skid_flags_q;
            end
            if (load_skid) begin
                skid_data_q  <= IN_DATA;
                skid_flags_q <= in_flags;
            end
            if (pop) begin
                dcnt_q <= dcnt_q + 8'd1;
            end
        end
    end

    assign OUT_DATA = main_data_q;
    assign OUT_Z    = main_flags_q.z;
    assign OUT_N    = main_flags_q.n;
`ifdef ALU_PARITY_FLAG_EN
    assign OUT_P    = main_flags_q.p;
`endif
    assign DCNT     = dcnt_q;

endmodule

// File: tb/tb_alu_result_buffer8.sv
// Self-checking bench for alu_result_buffer8: directed vector table, reset/ramp sequences,
// and a random handshake run against a queue scoreboard. Honours ALU_PARITY_FLAG_EN.
module tb_alu_result_buffer8;

    logic       CLK;
    logic       RST;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] IN_DATA;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [7:0] OUT_DATA;
    logic       OUT_Z;
    logic       OUT_N;
`ifdef ALU_PARITY_FLAG_EN
    logic       OUT_P;
`endif
    logic [7:0] DCNT;

    int n_checks = 0;
    int n_fail   = 0;

    alu_result_buffer8 dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_DATA   (IN_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .OUT_Z     (OUT_Z),
        .OUT_N     (OUT_N),
`ifdef ALU_PARITY_FLAG_EN
        .OUT_P     (OUT_P),
`endif
        .DCNT      (DCNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       in_valid;
        logic [7:0] in_data;
        logic       out_ready;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_z;
        logic       exp_n;
        logic       exp_p;
        logic       exp_in_ready;
        logic [7:0] exp_dcnt;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_flags(input string name, input logic [7:0] d);
        check({name, "_z"}, {31'd0, OUT_Z}, {31'd0, d == 8'h00});
        check({name, "_n"}, {31'd0, OUT_N}, {31'd0, d[7]});
`ifdef ALU_PARITY_FLAG_EN
        check({name, "_p"}, {31'd0, OUT_P}, {31'd0, ^d});
`endif
    endtask

    logic [7:0] sb[$];
    logic [7:0] m_dcnt;
    logic [7:0] cur_data;
    logic       cur_valid;
    logic       m_push, m_pop;

    initial begin
        // {in_valid, in_data, out_ready, exp_valid, exp_data, z, n, p, in_ready, dcnt}
        vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
        vecs[2]  = '{1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
        vecs[4]  = '{1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
        vecs[5]  = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
        vecs[6]  = '{1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
        vecs[7]  = '{1'b1, 8'h33, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3};
        vecs[8]  = '{1'b1, 8'h33, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5};
        vecs[10] = '{1'b1, 8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 1'b1, 8'd5};
        vecs[11] = '{1'b1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 1'b1, 8'd6};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 1'b1, 8'd6};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd7};

        RST       = 1'b1;
        IN_VALID  = 1'b0;
        IN_DATA   = 8'h00;
        OUT_READY = 1'b0;
        step();
        step();
        check("rst_in_ready", {31'd0, IN_READY}, 32'd0);
        check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("rst_out_data", {24'd0, OUT_DATA}, 32'h00);
        check("rst_z", {31'd0, OUT_Z}, 32'd0);
        check("rst_n", {31'd0, OUT_N}, 32'd0);
`ifdef ALU_PARITY_FLAG_EN
        check("rst_p", {31'd0, OUT_P}, 32'd0);
`endif
        check("rst_dcnt", {24'd0, DCNT}, 32'h00);
        RST = 1'b0;
        #1;
        check("rst_release_in_ready", {31'd0, IN_READY}, 32'd1);

        // Directed table
        for (int i = 0; i < 14; i++) begin
            IN_VALID  = vecs[i].in_valid;
            IN_DATA   = vecs[i].in_data;
            OUT_READY = vecs[i].out_ready;
            step();
            check($sformatf("vec%0d_valid", i), {31'd0, OUT_VALID}, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_in_ready", i), {31'd0, IN_READY},
                  {31'd0, vecs[i].exp_in_ready});
            check($sformatf("vec%0d_dcnt", i), {24'd0, DCNT}, {24'd0, vecs[i].exp_dcnt});
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_data", i), {24'd0, OUT_DATA}, {24'd0, vecs[i].exp_data});
                check($sformatf("vec%0d_z", i), {31'd0, OUT_Z}, {31'd0, vecs[i].exp_z});
                check($sformatf("vec%0d_n", i), {31'd0, OUT_N}, {31'd0, vecs[i].exp_n});
`ifdef ALU_PARITY_FLAG_EN
                check($sformatf("vec%0d_p", i), {31'd0, OUT_P}, {31'd0, vecs[i].exp_p});
`endif
            end
        end

        // Reset while holding two entries; push/pop during reset must be ignored
        IN_VALID  = 1'b1;
        OUT_READY = 1'b0;
        IN_DATA   = 8'hAA;
        step();
        IN_DATA   = 8'hBB;
        step();
        check("two_in_ready", {31'd0, IN_READY}, 32'd0);
        RST       = 1'b1;
        IN_DATA   = 8'hCC;
        OUT_READY = 1'b1;
        step();
        check("rst2_in_ready", {31'd0, IN_READY}, 32'd0);
        check("rst2_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("rst2_dcnt", {24'd0, DCNT}, 32'h00);
        check("rst2_out_data", {24'd0, OUT_DATA}, 32'h00);
        RST      = 1'b0;
        IN_VALID = 1'b0;
        #1;
        check("rst2_release_in_ready", {31'd0, IN_READY}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst2_no_stale", {31'd0, OUT_VALID}, 32'd0);
        end

        // Full-throughput ramp 0..299
        OUT_READY = 1'b1;
        IN_VALID  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            IN_DATA = i[7:0];
            step();
            check("ramp_valid", {31'd0, OUT_VALID}, 32'd1);
            check("ramp_data", {24'd0, OUT_DATA}, {24'd0, i[7:0]});
            check("ramp_in_ready", {31'd0, IN_READY}, 32'd1);
        end
        IN_VALID = 1'b0;
        step();
        check("ramp_drained", {31'd0, OUT_VALID}, 32'd0);
        check("ramp_dcnt_wrap", {24'd0, DCNT}, 32'd44);

        // Random handshakes against a queue scoreboard
        m_dcnt    = 8'd44;
        cur_valid = 1'b0;
        cur_data  = 8'h00;
        for (int c = 0; c < 1100; c++) begin
            check("rnd_valid", {31'd0, OUT_VALID}, {31'd0, sb.size() != 0});
            check("rnd_in_ready", {31'd0, IN_READY}, {31'd0, sb.size() != 2});
            check("rnd_dcnt", {24'd0, DCNT}, {24'd0, m_dcnt});
            if (sb.size() != 0) begin
                check("rnd_data", {24'd0, OUT_DATA}, {24'd0, sb[0]});
                check_flags("rnd", sb[0]);
            end
            if (!cur_valid && c < 1000 && $urandom_range(0, 3) != 0) begin
                cur_valid = 1'b1;
                cur_data  = 8'($urandom_range(0, 255));
            end
            IN_VALID  = cur_valid;
            IN_DATA   = cur_data;
            OUT_READY = (c >= 1000) ? 1'b1 : ($urandom_range(0, 2) != 0);
            m_push    = cur_valid && (sb.size() != 2);
            m_pop     = (sb.size() != 0) && OUT_READY;
            step();
            if (m_pop) begin
                void'(sb.pop_front());
                m_dcnt = m_dcnt + 8'd1;
            end
            if (m_push) begin
                sb.push_back(cur_data);
                cur_valid = 1'b0;
            end
        end
        IN_VALID = 1'b0;
        check("rnd_drained", {31'd0, sb.size() == 0}, 32'd1);
        check("rnd_final_valid", {31'd0, OUT_VALID}, 32'd0);
        check("rnd_final_dcnt", {24'd0, DCNT}, {24'd0, m_dcnt});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
